// File: rtl/systolic_array_32x32_ws_pkg.sv
// Shared defaults for the weight-stationary systolic array.
// Holds the array dimensions and the operand/partial-sum widths used as
// parameter defaults by systolic_pe and systolic_array_32x32_ws.
package systolic_array_32x32_ws_pkg;

  localparam int ROW_NUM_DEF      = 32;  // PE rows (activation inputs)
  localparam int COL_NUM_DEF      = 32;  // PE columns (weight inputs, outputs)
  localparam int DATA_WIDTH_A_DEF = 4;   // signed activation width
  localparam int DATA_WIDTH_W_DEF = 8;   // signed weight width
  localparam int DATA_WIDTH_P_DEF = 32;  // partial-sum / output width

endpackage

// File: rtl/systolic_array_32x32_ws_pe.sv
// systolic_pe: one weight-stationary multiply-accumulate cell.
// Ports:
//   clk, rst         - rising-edge clock, async active-high reset
//   load_weight_en   - 1: shift weight down, clear partial sum; 0: compute
//   a_in             - activation from the left neighbour (or array edge)
//   w_in             - weight from the upper neighbour (or array edge)
//   p_in             - partial sum from the upper neighbour (0 on top row)
//   a_q, w_q, p_q    - registered activation, weight and partial sum
module systolic_pe
  import systolic_array_32x32_ws_pkg::*;
#(
  parameter int DATA_WIDTH_A = DATA_WIDTH_A_DEF,
  parameter int DATA_WIDTH_W = DATA_WIDTH_W_DEF,
  parameter int DATA_WIDTH_P = DATA_WIDTH_P_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_weight_en,
  input  logic [DATA_WIDTH_A-1:0] a_in,
  input  logic [DATA_WIDTH_W-1:0] w_in,
  input  logic [DATA_WIDTH_P-1:0] p_in,
  output logic [DATA_WIDTH_A-1:0] a_q,
  output logic [DATA_WIDTH_W-1:0] w_q,
  output logic [DATA_WIDTH_P-1:0] p_q
);

  logic signed [DATA_WIDTH_P-1:0] a_ext;
  logic signed [DATA_WIDTH_P-1:0] w_ext;
  logic        [DATA_WIDTH_P-1:0] prod;

  // Sign-extend (or truncate) both operands to the accumulator width first;
  // the low DATA_WIDTH_P bits of the product are then exact modulo 2^P.
  assign a_ext = DATA_WIDTH_P'($signed(a_in));
  assign w_ext = DATA_WIDTH_P'($signed(w_q));
  assign prod  = a_ext * w_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      w_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_in;
      if (load_weight_en) begin
        w_q <= w_in;
        p_q <= '0;
      end else begin
        p_q <= p_in + prod;
      end
    end
  end

endmodule

// File: rtl/systolic_array_32x32_ws.sv
// systolic_array_32x32_ws: ROW_NUM x COL_NUM weight-stationary MAC grid.
// Weights shift in from the top, skewed activations enter from the left,
// partial sums flow down and leave the bottom row.
// Ports:
//   clk, rst         - rising-edge clock, async active-high reset
//   load_weight_en   - 1: shift weights down one row; 0: compute
//   row_in_flat      - activation for row r at [r*DATA_WIDTH_A +: DATA_WIDTH_A]
//   col_in_flat      - weight for column c at [c*DATA_WIDTH_W +: DATA_WIDTH_W]
//   col_out_flat     - bottom-row sum for column c at [c*DATA_WIDTH_P +: DATA_WIDTH_P]
module systolic_array_32x32_ws
  import systolic_array_32x32_ws_pkg::*;
#(
  parameter int ROW_NUM      = ROW_NUM_DEF,
  parameter int COL_NUM      = COL_NUM_DEF,
  parameter int DATA_WIDTH_A = DATA_WIDTH_A_DEF,
  parameter int DATA_WIDTH_W = DATA_WIDTH_W_DEF,
  parameter int DATA_WIDTH_P = DATA_WIDTH_P_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_weight_en,
  input  logic [ROW_NUM*DATA_WIDTH_A-1:0] row_in_flat,
  input  logic [COL_NUM*DATA_WIDTH_W-1:0] col_in_flat,
  output logic [COL_NUM*DATA_WIDTH_P-1:0] col_out_flat
);

  logic [DATA_WIDTH_A-1:0] a_q [ROW_NUM][COL_NUM];
  logic [DATA_WIDTH_W-1:0] w_q [ROW_NUM][COL_NUM];
  logic [DATA_WIDTH_P-1:0] p_q [ROW_NUM][COL_NUM];

  for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
    for (genvar c = 0; c < COL_NUM; c++) begin : g_col
      logic [DATA_WIDTH_A-1:0] a_in;
      logic [DATA_WIDTH_W-1:0] w_in;
      logic [DATA_WIDTH_P-1:0] p_in;

      if (c == 0) begin : g_left
        assign a_in = row_in_flat[r*DATA_WIDTH_A +: DATA_WIDTH_A];
      end else begin : g_inner_a
        assign a_in = a_q[r][c-1];
      end

      if (r == 0) begin : g_top
        assign w_in = col_in_flat[c*DATA_WIDTH_W +: DATA_WIDTH_W];
        assign p_in = '0;
      end else begin : g_inner_wp
        assign w_in = w_q[r-1][c];
        assign p_in = p_q[r-1][c];
      end

      systolic_pe #(
        .DATA_WIDTH_A (DATA_WIDTH_A),
        .DATA_WIDTH_W (DATA_WIDTH_W),
        .DATA_WIDTH_P (DATA_WIDTH_P)
      ) u_pe (
        .clk            (clk),
        .rst            (rst),
        .load_weight_en (load_weight_en),
        .a_in           (a_in),
        .w_in           (w_in),
        .p_in           (p_in),
        .a_q            (a_q[r][c]),
        .w_q            (w_q[r][c]),
        .p_q            (p_q[r][c])
      );
    end
  end

  for (genvar c = 0; c < COL_NUM; c++) begin : g_out
    assign col_out_flat[c*DATA_WIDTH_P +: DATA_WIDTH_P] = p_q[ROW_NUM-1][c];
  end

endmodule

// File: tb/tb_systolic_array_32x32_ws.sv
module tb_systolic_array_32x32_ws;

  localparam int R  = 32;
  localparam int C  = 32;
  localparam int AW = 4;
  localparam int WW = 8;
  localparam int PW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_weight_en;
  logic [R*AW-1:0] row_in_flat;
  logic [C*WW-1:0] col_in_flat;
  logic [C*PW-1:0] col_out_flat;
  logic [C*8-1:0]  col_out8_flat;

  int errors = 0;
  int checks = 0;
  int wt  [R][C];
  int act [R][R];
  int k_len;

  always #5 clk = ~clk;

  systolic_array_32x32_ws dut (
    .clk            (clk),
    .rst            (rst),
    .load_weight_en (load_weight_en),
    .row_in_flat    (row_in_flat),
    .col_in_flat    (col_in_flat),
    .col_out_flat   (col_out_flat)
  );

  // Narrow-accumulator build, fed the same inputs, to observe wrap-around.
  systolic_array_32x32_ws #(.DATA_WIDTH_P(8)) dut8 (
    .clk            (clk),
    .rst            (rst),
    .load_weight_en (load_weight_en),
    .row_in_flat    (row_in_flat),
    .col_in_flat    (col_in_flat),
    .col_out_flat   (col_out8_flat)
  );

  // Present wt[n-1-j] on load cycle j so that PE(r,c).w = wt[r][c] for r < n.
  task automatic load_weights(input int n);
    int v;
    row_in_flat    = '0;
    load_weight_en = 1'b1;
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < C; c++) begin
        v = wt[n-1-j][c];
        col_in_flat[c*WW +: WW] = v[WW-1:0];
      end
      @(posedge clk); #1;
    end
    load_weight_en = 1'b0;
    col_in_flat    = '0;
  endtask

  // Drive the skewed activations for compute edge t, then clock once.
  task automatic drive_edge(input int t);
    int k;
    int v;
    for (int r = 0; r < R; r++) begin
      k = t - r;
      v = (k >= 0 && k < k_len) ? act[r][k] : 0;
      row_in_flat[r*AW +: AW] = v[AW-1:0];
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst            = 1'b1;
    load_weight_en = 1'b0;
    row_in_flat    = '0;
    col_in_flat    = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (col_out_flat !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", col_out_flat);
    end
    checks++;
    if (col_out8_flat !== '0) begin
      errors++;
      $display("FAIL reset_state_p8 got=%h exp=0", col_out8_flat);
    end
    rst = 1'b0;
  endtask

  task automatic test_uniform;
    logic [PW-1:0] got, exp;
    int k;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wt[r][c] = r % 8;
    k_len = 32;
    for (int r = 0; r < R; r++)
      for (int kk = 0; kk < k_len; kk++) act[r][kk] = kk % 8;
    load_weights(R);
    for (int t = 0; t < k_len + R + C - 1; t++) begin
      drive_edge(t);
      for (int c = 0; c < C; c++) begin
        k = t - (R - 1) - c;
        if (k >= 0 && k < k_len) begin
          exp = PW'(112 * (k % 8));
          got = col_out_flat[c*PW +: PW];
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL uniform c=%0d k=%0d got=%0d exp=%0d", c, k, got, exp);
          end
        end
      end
    end
  endtask

  task automatic test_sign;
    logic [PW-1:0] got;
    logic [7:0]    got8;
    int k;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wt[r][c] = -1;
    k_len = 4;
    for (int r = 0; r < R; r++)
      for (int kk = 0; kk < k_len; kk++) act[r][kk] = -8;
    load_weights(R);
    for (int t = 0; t < k_len + R + C - 1; t++) begin
      drive_edge(t);
      for (int c = 0; c < C; c++) begin
        k = t - (R - 1) - c;
        if (k >= 0 && k < k_len) begin
          got  = col_out_flat[c*PW +: PW];
          got8 = col_out8_flat[c*8 +: 8];
          checks++;
          if (got !== 32'd256) begin
            errors++;
            $display("FAIL sign c=%0d k=%0d got=%0d exp=256", c, k, got);
          end
          checks++;
          if (got8 !== 8'd0) begin
            errors++;
            $display("FAIL sign_p8 c=%0d k=%0d got=%0d exp=0", c, k, got8);
          end
        end
      end
    end
  endtask

  task automatic test_wrap;
    logic [PW-1:0] got;
    logic [7:0]    got8;
    int k;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wt[r][c] = 127;
    k_len = 4;
    for (int r = 0; r < R; r++)
      for (int kk = 0; kk < k_len; kk++) act[r][kk] = 7;
    load_weights(R);
    for (int t = 0; t < k_len + R + C - 1; t++) begin
      drive_edge(t);
      for (int c = 0; c < C; c++) begin
        k = t - (R - 1) - c;
        if (k >= 0 && k < k_len) begin
          got  = col_out_flat[c*PW +: PW];
          got8 = col_out8_flat[c*8 +: 8];
          checks++;
          if (got !== 32'd28448) begin
            errors++;
            $display("FAIL wrap_p32 c=%0d k=%0d got=%0d exp=28448", c, k, got);
          end
          checks++;
          if (got8 !== 8'd32) begin
            errors++;
            $display("FAIL wrap_p8 c=%0d k=%0d got=%0d exp=32", c, k, got8);
          end
        end
      end
    end
  endtask

  task automatic identity_stream(input string name);
    logic [PW-1:0] got, exp;
    int k;
    k_len = 8;
    for (int r = 0; r < R; r++)
      for (int kk = 0; kk < k_len; kk++) act[r][kk] = r % 8;
    for (int t = 0; t < k_len + R + C - 1; t++) begin
      drive_edge(t);
      for (int c = 0; c < C; c++) begin
        k = t - (R - 1) - c;
        if (k >= 0 && k < k_len) begin
          exp = PW'(c % 8);
          got = col_out_flat[c*PW +: PW];
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL %s c=%0d k=%0d got=%0d exp=%0d", name, c, k, got, exp);
          end
        end
      end
    end
  endtask

  task automatic test_identity;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wt[r][c] = (r == c) ? 1 : 0;
    load_weights(R);
    identity_stream("identity");
  endtask

  task automatic test_weight_hold;
    identity_stream("weight_hold");
  endtask

  task automatic test_reset_mid_compute;
    logic [PW-1:0] got;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wt[r][c] = r % 8;
    k_len = 32;
    for (int r = 0; r < R; r++)
      for (int kk = 0; kk < k_len; kk++) act[r][kk] = kk % 8;
    load_weights(R);
    for (int t = 0; t <= 40; t++) drive_edge(t);
    // edge 40, column 0 carries vector k=9 -> 112
    got = col_out_flat[0 +: PW];
    checks++;
    if (got !== 32'd112) begin
      errors++;
      $display("FAIL pre_reset c=0 got=%0d exp=112", got);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (col_out_flat !== '0) begin
      errors++;
      $display("FAIL reset_immediate got=%h exp=0", col_out_flat);
    end
    row_in_flat = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (col_out_flat !== '0) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d got=%h exp=0", i, col_out_flat);
      end
    end
  endtask

  // One load cycle after reset: only the top row receives a weight.
  task automatic test_partial_load;
    logic [PW-1:0] got;
    int k;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wt[r][c] = (r == 0) ? 5 : 9;
    load_weights(1);
    k_len = 4;
    for (int r = 0; r < R; r++)
      for (int kk = 0; kk < k_len; kk++) act[r][kk] = 1;
    for (int t = 0; t < k_len + R + C - 1; t++) begin
      drive_edge(t);
      for (int c = 0; c < C; c++) begin
        k = t - (R - 1) - c;
        if (k >= 0 && k < k_len) begin
          got = col_out_flat[c*PW +: PW];
          checks++;
          if (got !== 32'd5) begin
            errors++;
            $display("FAIL partial_load c=%0d k=%0d got=%0d exp=5", c, k, got);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_sign();
    test_wrap();
    test_identity();
    test_weight_hold();
    test_reset_mid_compute();
    test_partial_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
